// File: rtl/channel_arb_pkg.sv
// Shared types and helpers for the channel readout arbiter.
// Contents: arbiter FSM state enum, channel-index width helper.
package channel_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  // Width of an index into n channels, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/channel_readout_arbiter_if.sv
// Valid/ready readout port carrying one channel index per transfer.
// Signals: out_valid (offer), out_ready (accept), out_channel (offered index).
// Modports: master = arbiter side, slave = readout-logic side.
interface channel_readout_arbiter_if
  import channel_arb_pkg::*;
#(
  parameter  int unsigned CHANNELS = 10,
  localparam int unsigned CH_W     = idx_width(CHANNELS)
);

  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_channel;

  modport master (output out_valid, output out_channel, input out_ready);
  modport slave  (input out_valid, input out_channel, output out_ready);

endinterface

// File: rtl/rr_priority_encoder.sv
// Round-robin find-first: returns the first set request after 'last',
// wrapping from CHANNELS-1 to 0. Purely combinational.
// Ports: req (requests), last (previous winner), gnt_valid, gnt_idx.
module rr_priority_encoder
  import channel_arb_pkg::*;
#(
  parameter  int unsigned CHANNELS = 10,
  localparam int unsigned CH_W     = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     last,
  output logic                gnt_valid,
  output logic [CH_W-1:0]     gnt_idx
);

  localparam int unsigned IW = CH_W + 1;

  logic [IW-1:0]         base;
  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [IW-1:0]         off;
  logic [IW-1:0]         sum;

  always_comb begin
    // Rotate so that bit 0 of rot is channel last+1.
    base = {1'b0, last} + IW'(1);
    if (base >= IW'(CHANNELS)) base = '0;
    dbl = {req, req};
    rot = CHANNELS'(dbl >> base);

    // Find first set bit; descending scan lets the lowest index win.
    gnt_valid = 1'b0;
    off       = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_valid = 1'b1;
        off       = IW'(j);
      end
    end

    // Un-rotate back to an absolute channel index.
    sum = base + off;
    if (sum >= IW'(CHANNELS)) sum = sum - IW'(CHANNELS);
    gnt_idx = CH_W'(sum);
  end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin readout scheduler: captures rising edges on per-channel hit
// lines as pending events and serialises them onto one valid/ready port.
// Ports: clk, rst (sync, active-high), hit/mask (per channel),
//        rd (readout port, master side), ovf_count (saturating lost-event
//        count), ovf_clear (sync clear of ovf_count).
module channel_readout_arbiter
  import channel_arb_pkg::*;
#(
  parameter  int unsigned CHANNELS = 10,
  parameter  int unsigned OVF_W    = 8,
  localparam int unsigned CH_W     = idx_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  hit,
  input  logic [CHANNELS-1:0]  mask,
  channel_readout_arbiter_if.master rd,
  output logic [OVF_W-1:0]     ovf_count,
  input  logic                 ovf_clear
);

  localparam int unsigned     SUM_W    = OVF_W + CH_W + 1;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  arb_state_e          state;
  logic [CHANNELS-1:0] hit_q;
  logic [CHANNELS-1:0] pending;
  logic [CH_W-1:0]     last;
  logic                valid_q;
  logic [CH_W-1:0]     channel_q;
  logic [OVF_W-1:0]    ovf_q;

  logic                accept;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] acc_vec;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] pending_nxt;
  logic [CHANNELS-1:0] ovf_vec;
  logic [CH_W:0]       pop;
  logic [SUM_W-1:0]    ovf_sum;
  logic [OVF_W-1:0]    ovf_nxt;
  logic [CH_W-1:0]     search_base;
  logic                gnt_valid;
  logic [CH_W-1:0]     gnt_idx;

  assign rd.out_valid   = valid_q;
  assign rd.out_channel = channel_q;
  assign ovf_count      = ovf_q;

  // Edge capture, pending update, overflow detection and next search base.
  always_comb begin
    accept = valid_q & rd.out_ready;
    rise   = hit & ~hit_q & ~mask;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_vec[i] = accept & (channel_q == CH_W'(i));
    end
    cand        = pending & ~acc_vec;
    // A new edge wins over the accept-clear of the same channel.
    pending_nxt = (pending & ~acc_vec & ~mask) | rise;
    ovf_vec     = rise & pending & ~acc_vec;

    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + (CH_W + 1)'(ovf_vec[i]);
    end
    ovf_sum = SUM_W'(ovf_q) + SUM_W'(pop);
    ovf_nxt = (ovf_sum > SUM_W'(OVF_MAX)) ? OVF_MAX : OVF_W'(ovf_sum);

    // On an accept the search restarts after the channel being accepted.
    search_base = accept ? channel_q : last;
  end

  rr_priority_encoder #(
    .CHANNELS (CHANNELS)
  ) u_rr (
    .req       (cand),
    .last      (search_base),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State, flags, offer registers and overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      hit_q     <= '0;
      pending   <= '0;
      last      <= CH_W'(CHANNELS - 1);
      valid_q   <= 1'b0;
      channel_q <= '0;
      ovf_q     <= '0;
    end else begin
      hit_q   <= hit;
      pending <= pending_nxt;
      ovf_q   <= ovf_clear ? '0 : ovf_nxt;

      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            channel_q <= gnt_idx;
            valid_q   <= 1'b1;
            state     <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (rd.out_ready) begin
            last <= channel_q;
            if (gnt_valid) begin
              channel_q <= gnt_idx;
            end else begin
              valid_q <= 1'b0;
              state   <= ARB_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Directed self-checking bench for channel_readout_arbiter (CHANNELS=10, OVF_W=8).
module tb_channel_readout_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] hit;
  logic [9:0] mask;
  logic [7:0] ovf_count;
  logic       ovf_clear;

  int n_vec;
  int n_err;

  channel_readout_arbiter_if #(.CHANNELS(10)) rd ();

  channel_readout_arbiter #(
    .CHANNELS (10),
    .OVF_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .mask      (mask),
    .rd        (rd),
    .ovf_count (ovf_count),
    .ovf_clear (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    hit       = '0;
    mask      = '0;
    ovf_clear = 1'b0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
  endtask

  task automatic chk_offer(input string tag, input logic v, input logic [3:0] ch);
    chk({tag, "_valid"}, 32'(rd.out_valid), 32'(v));
    if (v) chk({tag, "_chan"}, 32'(rd.out_channel), 32'(ch));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; hit = '0; mask = '0; ovf_clear = 1'b0; rd.out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 32'(rd.out_valid), 32'd0);
    chk("rst_chan", 32'(rd.out_channel), 32'd0);
    chk("rst_ovf", 32'(ovf_count), 32'd0);
    chk("rst_pend", 32'(dut.pending), 32'd0);
    rst = 1'b0;

    // Single event on channel 3
    rd.out_ready = 1'b1;
    hit = 10'h008;
    tick();
    chk("single_pend", 32'(dut.pending), 32'h008);
    chk_offer("single_e1", 1'b0, 4'd0);
    tick();
    chk_offer("single_e2", 1'b1, 4'd3);
    hit = '0;
    tick();
    chk_offer("single_e3", 1'b0, 4'd0);
    chk("single_ovf", 32'(ovf_count), 32'd0);

    // Fairness: 0,5,9 together from reset (last=9)
    do_reset();
    rd.out_ready = 1'b1;
    hit = 10'h221;
    tick();
    chk("fair_pend", 32'(dut.pending), 32'h221);
    tick(); chk_offer("fair_a0", 1'b1, 4'd0);
    tick(); chk_offer("fair_a5", 1'b1, 4'd5);
    tick(); chk_offer("fair_a9", 1'b1, 4'd9);
    hit = '0;
    tick(); chk_offer("fair_idle", 1'b0, 4'd0);
    hit = 10'h021;
    tick();
    tick(); chk_offer("fair_b0", 1'b1, 4'd0);
    tick(); chk_offer("fair_b5", 1'b1, 4'd5);
    hit = '0;
    tick(); chk_offer("fair_b_idle", 1'b0, 4'd0);

    // Backpressure on channel 2 with three extra edges
    do_reset();
    rd.out_ready = 1'b0;
    hit = 10'h004;
    tick();
    tick(); chk_offer("bp_start", 1'b1, 4'd2);
    begin
      logic [9:0] pat;
      pat = 10'b00_0010_1010;
      for (int k = 0; k < 10; k++) begin
        hit = pat[k] ? 10'h004 : 10'h000;
        tick();
        chk_offer("bp_hold", 1'b1, 4'd2);
      end
    end
    chk("bp_ovf", 32'(ovf_count), 32'd3);
    rd.out_ready = 1'b1;
    tick();
    chk_offer("bp_done", 1'b0, 4'd0);
    chk("bp_pend", 32'(dut.pending), 32'd0);
    tick();
    chk_offer("bp_idle", 1'b0, 4'd0);
    chk("bp_ovf_keep", 32'(ovf_count), 32'd3);

    // Same-cycle accept and new edge on channel 4
    do_reset();
    rd.out_ready = 1'b0;
    hit = 10'h010;
    tick();
    tick(); chk_offer("sc_offer", 1'b1, 4'd4);
    hit = '0;
    tick(); chk_offer("sc_hold", 1'b1, 4'd4);
    hit = 10'h010;
    rd.out_ready = 1'b1;
    tick();
    chk_offer("sc_acc", 1'b0, 4'd0);
    chk("sc_pend", 32'(dut.pending), 32'h010);
    chk("sc_ovf", 32'(ovf_count), 32'd0);
    tick(); chk_offer("sc_second", 1'b1, 4'd4);
    tick();
    chk_offer("sc_end", 1'b0, 4'd0);
    chk("sc_pend_end", 32'(dut.pending), 32'd0);
    chk("sc_ovf_end", 32'(ovf_count), 32'd0);
    hit = '0;

    // Masked channel 7 never produces a transfer
    do_reset();
    rd.out_ready = 1'b1;
    mask = 10'h080;
    hit = 10'h080;
    tick();
    chk("mask_pend", 32'(dut.pending), 32'd0);
    hit = '0;     tick();
    hit = 10'h080; tick();
    tick();
    chk_offer("mask_none", 1'b0, 4'd0);
    hit = '0; mask = '0;
    tick();

    // Mask clears pending; masking the offered channel keeps the offer
    rd.out_ready = 1'b0;
    hit = 10'h003;
    tick();
    tick(); chk_offer("mk_offer", 1'b1, 4'd0);
    mask = 10'h002;
    tick();
    chk("mk_pend1", 32'(dut.pending), 32'h001);
    chk_offer("mk_keep1", 1'b1, 4'd0);
    mask = 10'h003;
    tick();
    chk("mk_pend0", 32'(dut.pending), 32'd0);
    chk_offer("mk_keep0", 1'b1, 4'd0);
    rd.out_ready = 1'b1;
    tick();
    chk_offer("mk_done", 1'b0, 4'd0);
    hit = '0; mask = '0; rd.out_ready = 1'b0;

    // Overflow saturation: all channels pending, 10 overflows per rise
    do_reset();
    hit = 10'h3FF;
    tick();
    tick(); chk_offer("sat_offer", 1'b1, 4'd0);
    for (int r = 1; r <= 25; r++) begin
      hit = '0;      tick();
      hit = 10'h3FF; tick();
    end
    chk("sat_250", 32'(ovf_count), 32'd250);
    hit = '0;      tick();
    hit = 10'h3FF; tick();
    chk("sat_255", 32'(ovf_count), 32'd255);
    for (int r = 27; r <= 30; r++) begin
      hit = '0;      tick();
      hit = 10'h3FF; tick();
    end
    chk("sat_hold", 32'(ovf_count), 32'd255);
    chk_offer("sat_still", 1'b1, 4'd0);
    hit = '0;
    ovf_clear = 1'b1;
    tick();
    chk("clr_plain", 32'(ovf_count), 32'd0);
    hit = 10'h3FF;
    tick();
    chk("clr_wins", 32'(ovf_count), 32'd0);
    ovf_clear = 1'b0;
    hit = '0;      tick();
    hit = 10'h3FF; tick();
    chk("clr_after", 32'(ovf_count), 32'd10);

    // Reset while an offer is stalled
    chk_offer("rst_mid_pre", 1'b1, 4'd0);
    rst = 1'b1;
    hit = '0;
    tick();
    chk("rst_mid_valid", 32'(rd.out_valid), 32'd0);
    chk("rst_mid_pend", 32'(dut.pending), 32'd0);
    chk("rst_mid_ovf", 32'(ovf_count), 32'd0);
    chk("rst_mid_chan", 32'(rd.out_channel), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_mid_idle", 32'(rd.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
